// File: rtl/passcode_checker.sv
// Four-digit passcode entry and compare: captures BCD digits on Enter presses,
// unlocks for a fixed time on a match, and locks out after repeated failures.
module passcode_checker #(
    parameter logic [15:0] CODE           = 16'h1234,
    parameter int          MAX_TRIES      = 3,
    parameter int          UNLOCK_CYCLES  = 250000000,
    parameter int          LOCKOUT_CYCLES = 250000000
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [3:0]  i_Digit,
    input  logic        i_Enter,
    input  logic        i_Clear,
    output logic [1:0]  o_Digit_Idx,
    output logic [15:0] o_Entry,
    output logic        o_Unlocked,
    output logic        o_Locked_Out,
    output logic        o_Error,
    output logic [3:0]  o_Fail_Count
);

    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {ENTRY, CHECK, OPEN, LOCKOUT} state_t;

    state_t        r_State, w_State_Nxt;
    logic [15:0]   r_Entry, w_Entry_Nxt;
    logic [1:0]    r_Idx, w_Idx_Nxt;
    logic [3:0]    r_Fail, w_Fail_Nxt;
    logic [TW-1:0] r_Timer, w_Timer_Nxt;
    logic          r_Error, w_Error_Nxt;
    logic          r_Unlocked, r_Locked_Out;
    logic          r_Enter_Prev, r_Clear_Prev;
    logic          w_Enter_Press, w_Clear_Press;
    logic [4:0]    w_Fail_Inc;

    assign w_Enter_Press = i_Enter & ~r_Enter_Prev;
    assign w_Clear_Press = i_Clear & ~r_Clear_Prev;
    assign w_Fail_Inc    = {1'b0, r_Fail} + 5'd1;

    always_comb begin
        w_State_Nxt = r_State;
        w_Entry_Nxt = r_Entry;
        w_Idx_Nxt   = r_Idx;
        w_Fail_Nxt  = r_Fail;
        w_Timer_Nxt = r_Timer;
        w_Error_Nxt = 1'b0;
        case (r_State)
            ENTRY: begin
                // Clear takes priority over a simultaneous Enter
                if (w_Clear_Press) begin
                    w_Entry_Nxt = 16'h0;
                    w_Idx_Nxt   = 2'd0;
                end else if (w_Enter_Press) begin
                    if (i_Digit > 4'd9) begin
                        w_Error_Nxt = 1'b1;
                    end else begin
                        case (r_Idx)
                            2'd0: w_Entry_Nxt[15:12] = i_Digit;
                            2'd1: w_Entry_Nxt[11:8]  = i_Digit;
                            2'd2: w_Entry_Nxt[7:4]   = i_Digit;
                            default: w_Entry_Nxt[3:0] = i_Digit;
                        endcase
                        w_Idx_Nxt = r_Idx + 2'd1;
                        if (r_Idx == 2'd3) w_State_Nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                if (r_Entry == CODE) begin
                    w_State_Nxt = OPEN;
                    w_Fail_Nxt  = 4'd0;
                end else begin
                    w_Error_Nxt = 1'b1;
                    if (r_Fail < 4'(MAX_TRIES)) w_Fail_Nxt = r_Fail + 4'd1;
                    if (w_Fail_Inc >= 5'(MAX_TRIES)) begin
                        w_State_Nxt = LOCKOUT;
                    end else begin
                        w_State_Nxt = ENTRY;
                        w_Entry_Nxt = 16'h0;
                    end
                end
            end
            OPEN: begin
                if (w_Clear_Press || r_Timer == TW'(UNLOCK_CYCLES - 1)) begin
                    w_State_Nxt = ENTRY;
                    w_Entry_Nxt = 16'h0;
                end else begin
                    w_Timer_Nxt = r_Timer + 1'b1;
                end
            end
            LOCKOUT: begin
                if (r_Timer == TW'(LOCKOUT_CYCLES - 1)) begin
                    w_State_Nxt = ENTRY;
                    w_Fail_Nxt  = 4'd0;
                    w_Entry_Nxt = 16'h0;
                end else begin
                    w_Timer_Nxt = r_Timer + 1'b1;
                end
            end
            default: w_State_Nxt = ENTRY;
        endcase
        if (w_State_Nxt != r_State) w_Timer_Nxt = '0;
    end

    // Edge-detect history resets high so a held switch is not a press
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State      <= ENTRY;
            r_Entry      <= 16'h0;
            r_Idx        <= 2'd0;
            r_Fail       <= 4'd0;
            r_Timer      <= '0;
            r_Error      <= 1'b0;
            r_Unlocked   <= 1'b0;
            r_Locked_Out <= 1'b0;
            r_Enter_Prev <= 1'b1;
            r_Clear_Prev <= 1'b1;
        end else begin
            r_State      <= w_State_Nxt;
            r_Entry      <= w_Entry_Nxt;
            r_Idx        <= w_Idx_Nxt;
            r_Fail       <= w_Fail_Nxt;
            r_Timer      <= w_Timer_Nxt;
            r_Error      <= w_Error_Nxt;
            r_Unlocked   <= (w_State_Nxt == OPEN);
            r_Locked_Out <= (w_State_Nxt == LOCKOUT);
            r_Enter_Prev <= i_Enter;
            r_Clear_Prev <= i_Clear;
        end
    end

    assign o_Digit_Idx  = r_Idx;
    assign o_Entry      = r_Entry;
    assign o_Unlocked   = r_Unlocked;
    assign o_Locked_Out = r_Locked_Out;
    assign o_Error      = r_Error;
    assign o_Fail_Count = r_Fail;

endmodule

// File: tb/tb_passcode_checker.sv
// Directed bench for passcode_checker with short timers (unlock 8, lockout 16).
module tb_passcode_checker;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic [3:0]  i_Digit = 4'd0;
    logic        i_Enter = 1'b0;
    logic        i_Clear = 1'b0;
    logic [1:0]  o_Digit_Idx;
    logic [15:0] o_Entry;
    logic        o_Unlocked;
    logic        o_Locked_Out;
    logic        o_Error;
    logic [3:0]  o_Fail_Count;

    int errors = 0;
    int checks = 0;

    passcode_checker #(
        .CODE(16'h1234), .MAX_TRIES(3), .UNLOCK_CYCLES(8), .LOCKOUT_CYCLES(16)
    ) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Digit(i_Digit), .i_Enter(i_Enter),
        .i_Clear(i_Clear), .o_Digit_Idx(o_Digit_Idx), .o_Entry(o_Entry),
        .o_Unlocked(o_Unlocked), .o_Locked_Out(o_Locked_Out), .o_Error(o_Error),
        .o_Fail_Count(o_Fail_Count)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One idle cycle, then an Enter press; returns just after the capturing edge
    task automatic press(input logic [3:0] d);
        i_Enter = 1'b0;
        tick();
        i_Digit = d;
        i_Enter = 1'b1;
        tick();
        i_Enter = 1'b0;
    endtask

    task automatic clear_press();
        i_Clear = 1'b0;
        tick();
        i_Clear = 1'b1;
        tick();
        i_Clear = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        press(c[15:12]);
        press(c[11:8]);
        press(c[7:4]);
        press(c[3:0]);
    endtask

    initial begin
        #2;
        chk("rst_entry", 32'(o_Entry), 32'h0);
        chk("rst_idx", 32'(o_Digit_Idx), 32'd0);
        chk("rst_fail", 32'(o_Fail_Count), 32'd0);
        chk("rst_flags", {29'd0, o_Unlocked, o_Locked_Out, o_Error}, 32'd0);
        tick();
        i_Rst = 1'b0;
        tick();

        // Correct code
        enter_code(16'h1234);
        chk("ok_entry", 32'(o_Entry), 32'h1234);
        chk("ok_idx", 32'(o_Digit_Idx), 32'd0);
        chk("ok_check_unl", 32'(o_Unlocked), 32'd0);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("ok_unlocked", 32'(o_Unlocked), 32'd1);
            tick();
        end
        chk("ok_relock", 32'(o_Unlocked), 32'd0);
        chk("ok_clr_entry", 32'(o_Entry), 32'h0);

        // Wrong code
        enter_code(16'h1235);
        tick();
        chk("bad_err", 32'(o_Error), 32'd1);
        chk("bad_fail", 32'(o_Fail_Count), 32'd1);
        chk("bad_entry", 32'(o_Entry), 32'h0);
        chk("bad_unl", 32'(o_Unlocked), 32'd0);
        tick();
        chk("bad_err_pulse", 32'(o_Error), 32'd0);

        // Two more failures reach lockout
        enter_code(16'h9999);
        tick();
        chk("bad2_fail", 32'(o_Fail_Count), 32'd2);
        chk("bad2_lock", 32'(o_Locked_Out), 32'd0);
        enter_code(16'h0000);
        tick();
        chk("lk_err", 32'(o_Error), 32'd1);
        chk("lk_fail", 32'(o_Fail_Count), 32'd3);
        i_Digit = 4'd7;
        for (int k = 0; k < 16; k++) begin
            chk("lk_locked", 32'(o_Locked_Out), 32'd1);
            chk("lk_idx", 32'(o_Digit_Idx), 32'd0);
            i_Enter = k[0];
            i_Clear = ~k[0];
            tick();
        end
        i_Enter = 1'b0;
        i_Clear = 1'b0;
        chk("lk_over", 32'(o_Locked_Out), 32'd0);
        chk("lk_fail_rst", 32'(o_Fail_Count), 32'd0);
        chk("lk_entry", 32'(o_Entry), 32'h0);
        chk("lk_idx_after", 32'(o_Digit_Idx), 32'd0);
        enter_code(16'h1234);
        tick();
        chk("lk_then_open", 32'(o_Unlocked), 32'd1);
        clear_press();
        chk("open_clr_unl", 32'(o_Unlocked), 32'd0);
        chk("open_clr_entry", 32'(o_Entry), 32'h0);

        // Clear and invalid digits
        press(4'd1);
        press(4'd2);
        chk("pc_entry", 32'(o_Entry), 32'h1200);
        chk("pc_idx", 32'(o_Digit_Idx), 32'd2);
        clear_press();
        chk("clr_entry", 32'(o_Entry), 32'h0);
        chk("clr_idx", 32'(o_Digit_Idx), 32'd0);
        press(4'd1);
        press(4'hA);
        chk("inv_err", 32'(o_Error), 32'd1);
        chk("inv_idx", 32'(o_Digit_Idx), 32'd1);
        chk("inv_entry", 32'(o_Entry), 32'h1000);
        tick();
        chk("inv_err_pulse", 32'(o_Error), 32'd0);
        i_Digit = 4'd5;
        i_Enter = 1'b1;
        i_Clear = 1'b1;
        tick();
        i_Enter = 1'b0;
        i_Clear = 1'b0;
        chk("both_entry", 32'(o_Entry), 32'h0);
        chk("both_idx", 32'(o_Digit_Idx), 32'd0);

        // Held Enter across reset release, then a long hold
        i_Rst = 1'b1;
        i_Digit = 4'd3;
        i_Enter = 1'b1;
        tick();
        tick();
        i_Rst = 1'b0;
        tick();
        tick();
        tick();
        chk("held_rst_idx", 32'(o_Digit_Idx), 32'd0);
        chk("held_rst_entry", 32'(o_Entry), 32'h0);
        i_Enter = 1'b0;
        tick();
        i_Enter = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        i_Enter = 1'b0;
        tick();
        chk("hold_idx", 32'(o_Digit_Idx), 32'd1);
        chk("hold_entry", 32'(o_Entry), 32'h3000);

        // Reset in the middle of OPEN
        clear_press();
        enter_code(16'h1234);
        tick();
        tick();
        tick();
        chk("mid_open", 32'(o_Unlocked), 32'd1);
        #2;
        i_Rst = 1'b1;
        #1;
        chk("mid_rst_unl", 32'(o_Unlocked), 32'd0);
        chk("mid_rst_entry", 32'(o_Entry), 32'h0);
        chk("mid_rst_misc", {22'd0, o_Digit_Idx, o_Fail_Count, o_Locked_Out, o_Error}, 32'd0);
        tick();
        i_Rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
